// File: rtl/sr_stream_pkg.sv
// +------------------------------------------------------------------+
// | sr_stream_pkg: shared types for the super-resolution pixel stream |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package sr_stream_pkg;

   localparam int SR_WORD_W   = 17;
   localparam int SOF_BIT     = 16;
   localparam int RGB_W       = 16;
   localparam int SR_H_ACTIVE = 640;
   localparam int SR_V_ACTIVE = 480;
   // Coordinate fields are sized for rasters up to 4096x4096.
   localparam int SR_COORD_W  = 12;

   typedef struct packed {
      logic [RGB_W-1:0]      rgb;
      logic [SR_COORD_W-1:0] x;
      logic [SR_COORD_W-1:0] y;
      logic                  sof;
      logic                  eol;
      logic                  eof;
   } sr_pix_t;

   typedef enum logic [0:0] {
      UNSYNC = 1'b0,
      SYNCED = 1'b1
   } sr_sync_e;

endpackage

`default_nettype wire

// File: rtl/sr_skid_buffer.sv
// +------------------------------------------------------------------+
// | sr_skid_buffer: 2-entry tagged-pixel FIFO with valid/ready output |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sr_skid_buffer
   import sr_stream_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  sr_pix_t    push_pix,
   input  logic       out_ready,
   output logic       out_valid,
   output sr_pix_t    head_pix,
   output logic [1:0] occ
);

   sr_pix_t    mem_q [2];
   sr_pix_t    mem_d [2];
   logic       wr_ptr_q, wr_ptr_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic [1:0] occ_q, occ_d;
   logic       pop;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      pop      = (occ_q != 2'd0) & out_ready;

      if (push) begin
         mem_d[wr_ptr_q] = push_pix;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end

      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign out_valid = (occ_q != 2'd0);
   assign head_pix  = mem_q[rd_ptr_q];
   assign occ       = occ_q;

endmodule

`default_nettype wire

// File: rtl/sr_fifo_reader.sv
// +------------------------------------------------------------------+
// | sr_fifo_reader: pops SR output FIFO, locks to sof, tags x/y/eol/eof |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sr_fifo_reader
   import sr_stream_pkg::*;
#(
   parameter  int H_ACTIVE  = SR_H_ACTIVE,
   parameter  int V_ACTIVE  = SR_V_ACTIVE,
   parameter  int CNT_W     = 10,
   parameter  int RD_THRESH = 0,
   localparam int X_W       = $clog2(H_ACTIVE),
   localparam int Y_W       = $clog2(V_ACTIVE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [SR_WORD_W-1:0] fifo_dout,
   input  logic [CNT_W-1:0]     fifo_count,
   output logic                 rd_fifo,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [RGB_W-1:0]     out_data,
   output logic [X_W-1:0]       out_x,
   output logic [Y_W-1:0]       out_y,
   output logic                 out_sof,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 synced,
   output logic                 sync_err
);

   localparam logic [X_W-1:0]   c_x_last = X_W'(H_ACTIVE - 1);
   localparam logic [Y_W-1:0]   c_y_last = Y_W'(V_ACTIVE - 1);
   localparam logic [CNT_W:0]   c_thresh = (CNT_W + 1)'(RD_THRESH);

   sr_sync_e       state_q, state_d;
   logic           inflight_q, inflight_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;
   logic           sync_err_q, sync_err_d;

   logic           word_sof;
   logic           at_origin;
   logic           push;
   logic [X_W-1:0] px;
   logic [Y_W-1:0] py;
   logic           pix_eol;
   logic           pix_eof;
   sr_pix_t        push_pix;
   sr_pix_t        head_pix;
   logic [1:0]     occ;
   logic           pop;
   logic           slot_used;
   logic           space;
   logic           avail;

   assign word_sof  = fifo_dout[SOF_BIT];
   assign at_origin = (x_q == '0) && (y_q == '0);
   assign pop       = out_valid & out_ready;

   // While unsynced only a returning sof word can claim a slot; it must still
   // fit, or a pop issued in the same cycle would overrun the buffer.
   assign slot_used = inflight_q & ((state_q == SYNCED) | word_sof);
   assign space     = ({1'b0, occ} + {2'b00, slot_used}) < (3'd2 + {2'b00, pop});
   assign avail     = {1'b0, fifo_count} > (c_thresh + {{CNT_W{1'b0}}, inflight_q});
   assign rd_fifo   = ~reset & avail & space;

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      y_d        = y_q;
      sync_err_d = 1'b0;
      inflight_d = rd_fifo;
      push       = 1'b0;
      px         = '0;
      py         = '0;

      if (inflight_q) begin
         if (state_q == UNSYNC) begin
            if (word_sof) begin
               push    = 1'b1;
               state_d = SYNCED;
            end
         end else if (word_sof) begin
            push       = 1'b1;
            sync_err_d = ~at_origin;
         end else if (at_origin) begin
            sync_err_d = 1'b1;
            state_d    = UNSYNC;
         end else begin
            push = 1'b1;
            px   = x_q;
            py   = y_q;
         end
      end

      pix_eol = (px == c_x_last);
      pix_eof = pix_eol && (py == c_y_last);

      if (push) begin
         x_d = pix_eol ? '0 : px + X_W'(1);
         y_d = pix_eol ? (pix_eof ? '0 : py + Y_W'(1)) : py;
      end

      push_pix     = '0;
      push_pix.rgb = fifo_dout[RGB_W-1:0];
      push_pix.x   = SR_COORD_W'(px);
      push_pix.y   = SR_COORD_W'(py);
      push_pix.sof = word_sof;
      push_pix.eol = pix_eol;
      push_pix.eof = pix_eof;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= UNSYNC;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight_q <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         sync_err_q <= 1'b0;
      end else begin
         inflight_q <= inflight_d;
         x_q        <= x_d;
         y_q        <= y_d;
         sync_err_q <= sync_err_d;
      end
   end

   sr_skid_buffer u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_pix  (push_pix),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .head_pix  (head_pix),
      .occ       (occ)
   );

   assign out_data = head_pix.rgb;
   assign out_x    = head_pix.x[X_W-1:0];
   assign out_y    = head_pix.y[Y_W-1:0];
   assign out_sof  = head_pix.sof;
   assign out_eol  = head_pix.eol;
   assign out_eof  = head_pix.eof;
   assign synced   = (state_q == SYNCED);
   assign sync_err = sync_err_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_fifo_reader.sv
// +------------------------------------------------------------------+
// | tb_sr_fifo_reader: directed + random bench with word-level model  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sr_fifo_reader;

   localparam int H     = 16;
   localparam int V     = 8;
   localparam int CNT_W = 10;
   localparam int XW    = $clog2(H);
   localparam int YW    = $clog2(V);

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [16:0]      fifo_dout = '0;
   logic [CNT_W-1:0] fifo_count = '0;
   logic             out_ready = 1'b0;
   logic             rd_fifo, out_valid, out_sof, out_eol, out_eof, synced, sync_err;
   logic [15:0]      out_data;
   logic [XW-1:0]    out_x;
   logic [YW-1:0]    out_y;

   sr_fifo_reader #(
      .H_ACTIVE (H), .V_ACTIVE (V), .CNT_W (CNT_W), .RD_THRESH (0)
   ) dut (
      .clk (clk), .reset (reset), .fifo_dout (fifo_dout), .fifo_count (fifo_count),
      .rd_fifo (rd_fifo), .out_valid (out_valid), .out_ready (out_ready),
      .out_data (out_data), .out_x (out_x), .out_y (out_y), .out_sof (out_sof),
      .out_eol (out_eol), .out_eof (out_eof), .synced (synced), .sync_err (sync_err)
   );

   always #5 clk = ~clk;

   logic [16:0] fq[$];
   logic [63:0] exp_q[$];
   logic [63:0] acc_log[$];
   int  n_checks = 0, n_err = 0, cyc = 0;
   bit  lag = 1'b0;
   int  prev_sz = 0;
   bit  m_sync = 1'b0;
   int  m_x = 0, m_y = 0, m_err = 0;
   int  gx = 0, gy = 0;
   int  acc_total = 0, pops_total = 0, err_obs = 0, err_run = 0, err_run_max = 0;
   int  eol_obs = 0, eof_obs = 0;
   bit  unsync_seen = 1'b0, valid_seen = 1'b0, last_pop = 1'b0, hold_v = 1'b0;
   logic [63:0] hold_val = '0;
   int  first_rd = -1, first_v = -1, acc_mark = 0, acc_c1 = -1, acc_cn = -1;

   function automatic logic [63:0] pk(input logic [15:0] rgb, input int x, input int y,
                                      input logic s, input logic e, input logic f);
      return {rgb, x[15:0], y[15:0], 13'd0, s, e, f};
   endfunction

   function automatic logic [63:0] obs_pk();
      return pk(out_data, int'(out_x), int'(out_y), out_sof, out_eol, out_eof);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Word-order model: raster position advances per accepted word, sof relocks.
   function automatic void model_word(input logic [16:0] w);
      bit eol, eof;
      if (w[16]) begin
         if (m_sync && (m_x != 0 || m_y != 0)) m_err++;
         m_sync = 1'b1;
         m_x = 0;
         m_y = 0;
      end else if (!m_sync) begin
         return;
      end else if (m_x == 0 && m_y == 0) begin
         m_err++;
         m_sync = 1'b0;
         return;
      end
      eol = (m_x == H - 1);
      eof = eol && (m_y == V - 1);
      exp_q.push_back(pk(w[15:0], m_x, m_y, w[16], eol, eof));
      m_x++;
      if (m_x == H) begin
         m_x = 0;
         m_y = (m_y + 1) % V;
      end
   endfunction

   function automatic void push_word(input logic [16:0] w);
      fq.push_back(w);
      model_word(w);
   endfunction

   function automatic void gen_word();
      logic [15:0] rgb;
      rgb = 16'($urandom);
      push_word({(gx == 0 && gy == 0), rgb});
      gx++;
      if (gx == H) begin
         gx = 0;
         gy = (gy + 1) % V;
      end
   endfunction

   task automatic tick();
      logic [63:0] o;
      logic        do_pop;
      int          cur;
      @(negedge clk);
      cyc++;
      o = obs_pk();
      if (hold_v) begin
         check("valid_held", 64'(out_valid), 64'd1);
         if (out_valid) check("stall_stable", o, hold_val);
      end
      hold_v   = out_valid & ~out_ready;
      hold_val = o;
      if (out_valid) begin
         valid_seen = 1'b1;
         if (first_v < 0) first_v = cyc;
      end
      if (!synced) unsync_seen = 1'b1;
      if (sync_err) begin
         err_obs++;
         err_run++;
         if (err_run > err_run_max) err_run_max = err_run;
      end else begin
         err_run = 0;
      end
      do_pop = rd_fifo;
      if (do_pop) begin
         pops_total++;
         if (first_rd < 0) first_rd = cyc;
         check("no_underflow", 64'(fq.size() == 0), 64'd0);
      end
      if (out_valid & out_ready) begin
         acc_total++;
         acc_log.push_back(o);
         if (out_eol) eol_obs++;
         if (out_eof) eof_obs++;
         if (acc_total - acc_mark == 1) acc_c1 = cyc;
         if (acc_total - acc_mark == H * V) acc_cn = cyc;
         if (exp_q.size() == 0) check("pixel_extra", 64'(exp_q.size()), 64'd1);
         else check("pixel", o, exp_q.pop_front());
      end
      last_pop = do_pop;
      @(posedge clk);
      #1;
      if (do_pop && fq.size() > 0) fifo_dout = fq.pop_front();
      cur        = fq.size();
      fifo_count = CNT_W'(lag ? prev_sz : cur);
      prev_sz    = cur;
   endtask

   task automatic drain(input int budget, input bit rnd, input string tag);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || fq.size() != 0) && n < budget) begin
         out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
         tick();
         n++;
      end
      check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
      out_ready = 1'b1;
      repeat (4) tick();
   endtask

   initial begin
      int e0, p0, a0, n;
      bit found;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_pix", obs_pk(), 64'd0);
      check("rst_ctl", 64'({out_valid, rd_fifo, synced, sync_err}), 64'd0);
      reset = 1'b0;
      tick();
      tick();
      check("idle_ctl", 64'({out_valid, rd_fifo, synced, sync_err}), 64'd0);

      // 1: lock on first sof word, earlier word dropped
      out_ready = 1'b1;
      acc_log.delete();
      push_word(17'h0AAAA);
      push_word(17'h1F800);
      push_word(17'h007E0);
      gx = 2;
      gy = 0;
      drain(40, 1'b0, "t1");
      check("t1_count", 64'(acc_log.size()), 64'd2);
      if (acc_log.size() >= 2) begin
         check("t1_px0", acc_log[0], pk(16'hF800, 0, 0, 1'b1, 1'b0, 1'b0));
         check("t1_px1", acc_log[1], pk(16'h07E0, 1, 0, 1'b0, 1'b0, 1'b0));
      end
      check("t1_synced", 64'(synced), 64'd1);

      while (!(gx == 0 && gy == 0)) gen_word();
      drain(H * V * 8, 1'b1, "t1_tail");

      // 2: full frame at full rate
      lag      = 1'b0;
      first_rd = -1;
      first_v  = -1;
      acc_mark = acc_total;
      eol_obs  = 0;
      eof_obs  = 0;
      for (int i = 0; i < H * V + 1; i++) gen_word();
      drain(H * V * 3, 1'b0, "t2");
      check("t2_latency", 64'(first_v - first_rd), 64'd2);
      check("t2_rate", 64'(acc_cn - acc_c1), 64'(H * V - 1));
      check("t2_eol_count", 64'(eol_obs), 64'(V));
      check("t2_eof_count", 64'(eof_obs), 64'd1);

      // 3: downstream stall with a deep FIFO
      lag       = 1'b1;
      out_ready = 1'b0;
      p0        = pops_total;
      a0        = acc_total;
      for (int i = 0; i < 100; i++) gen_word();
      repeat (20) begin
         tick();
         check("t3_outstanding_le2", 64'(((pops_total - p0) - (acc_total - a0)) <= 2), 64'd1);
      end
      check("t3_outstanding", 64'((pops_total - p0) - (acc_total - a0)), 64'd2);
      check("t3_rd_low", 64'(rd_fifo), 64'd0);
      drain(800, 1'b1, "t3");

      // 4: early sof mid-frame
      lag         = bit'($urandom_range(1));
      e0          = err_obs;
      err_run_max = 0;
      while (!(gx == 5 && gy == 3)) gen_word();
      push_word({1'b1, 16'($urandom)});
      gx = 1;
      gy = 0;
      repeat (10) gen_word();
      drain(H * V * 8, 1'b1, "t4");
      check("t4_err_pulses", 64'(err_obs - e0), 64'd1);
      check("t4_err_width", 64'(err_run_max), 64'd1);
      check("t4_synced", 64'(synced), 64'd1);

      // 5: missing sof after eof, then relock
      e0          = err_obs;
      err_run_max = 0;
      unsync_seen = 1'b0;
      while (!(gx == 0 && gy == 0)) gen_word();
      repeat (3) push_word({1'b0, 16'($urandom)});
      repeat (6) gen_word();
      drain(H * V * 8, 1'b1, "t5");
      check("t5_err_pulses", 64'(err_obs - e0), 64'd1);
      check("t5_err_width", 64'(err_run_max), 64'd1);
      check("t5_unsync_seen", 64'(unsync_seen), 64'd1);
      check("t5_relocked", 64'(synced), 64'd1);

      // 6: reset with one pixel buffered and one pop in flight
      lag       = 1'b0;
      out_ready = 1'b0;
      repeat (3) gen_word();
      found = 1'b0;
      n     = 0;
      while (!found && n < 20) begin
         tick();
         n++;
         found = out_valid && last_pop;
      end
      check("t6_setup", 64'(found), 64'd1);
      reset = 1'b1;
      #1;
      check("t6_pix_zero", obs_pk(), 64'd0);
      check("t6_ctl_zero", 64'({out_valid, rd_fifo, synced, sync_err}), 64'd0);
      hold_v = 1'b0;
      fq.delete();
      exp_q.delete();
      m_sync     = 1'b0;
      m_x        = 0;
      m_y        = 0;
      gx         = 0;
      gy         = 0;
      prev_sz    = 0;
      fifo_count = '0;
      tick();
      tick();
      reset      = 1'b0;
      out_ready  = 1'b1;
      valid_seen = 1'b0;
      repeat (5) tick();
      check("t6_quiet", 64'(valid_seen), 64'd0);
      repeat (8) gen_word();
      drain(200, 1'b1, "t6");
      check("t6_synced", 64'(synced), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
